// File: rtl/otter_pc_pkg.sv
// Shared types for the OTTER PC unit: next-PC source select and target alignment mask.
// Pure declarations; no latency or flow control of its own.
package otter_pc_pkg;

    typedef enum logic [2:0] {
        PC_SEL_TRAP,
        PC_SEL_HOLD,
        PC_SEL_BR,
        PC_SEL_RET,
        PC_SEL_SEQ
    } pc_sel_t;

    // Low address bits that must be zero for a legal redirect target.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/otter_ras.sv
// Circular return-address stack; top/empty/full valid from registered state, updates 1 cycle after push/pop.
// No backpressure: push on full overwrites the oldest entry, pop on empty is ignored.
module otter_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_dat_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   top_idx;
    logic            pop_ok;

    assign top_idx = ptr_q - PW'(1);
    assign top_o   = mem_q[top_idx];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(RAS_DEPTH));
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        case ({push_i, pop_ok})
            2'b10: begin
                ptr_d = ptr_q + PW'(1);
                if (!full_o) cnt_d = cnt_q + CW'(1);
            end
            2'b01: begin
                ptr_d = top_idx;
                cnt_d = cnt_q - CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Simultaneous push+pop replaces the top in place instead of advancing.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[pop_ok ? top_idx : ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/otter_pc_unit.sv
// Fetch-stage PC: priority next-PC select (trap > stall > branch > RAS return > sequential), 1-cycle latency.
// Stall holds PC and RAS; a trap still redirects. Misaligned targets are rejected with a 1-cycle flag.
module otter_pc_unit
    import otter_pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            pc_stall_i,
    input  logic            trap_en_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            br_en_i,
    input  logic [XLEN-1:0] br_tgt_i,
    input  logic            ras_push_i,
    input  logic            ras_pop_i,
    output logic [XLEN-1:0] pc_count_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ras_uflow_o,
    output logic            misalign_o
);

    pc_sel_t         sel;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_seq, ras_top;
    logic            uflow_q, uflow_d;
    logic            misalign_q, misalign_d;
    logic            ras_push, ras_pop;

    assign pc_seq = pc_q + XLEN'(INC);

    always_comb begin
        if (trap_en_i)                      sel = PC_SEL_TRAP;
        else if (pc_stall_i)                sel = PC_SEL_HOLD;
        else if (br_en_i)                   sel = PC_SEL_BR;
        else if (ras_pop_i && !ras_empty_o) sel = PC_SEL_RET;
        else                                sel = PC_SEL_SEQ;
    end

    assign misalign_d = ((sel == PC_SEL_TRAP) && ((trap_vec_i[1:0] & ALIGN_MASK) != '0)) ||
                        ((sel == PC_SEL_BR)   && ((br_tgt_i[1:0]   & ALIGN_MASK) != '0));

    always_comb begin
        pc_d = pc_q;
        case (sel)
            PC_SEL_TRAP: pc_d = trap_vec_i;
            PC_SEL_BR:   pc_d = br_tgt_i;
            PC_SEL_RET:  pc_d = ras_top;
            PC_SEL_SEQ:  pc_d = pc_seq;
            default:     pc_d = pc_q;
        endcase
        if (misalign_d) pc_d = pc_q;
    end

    // Trap and stall freeze the stack; a rejected redirect must not leave a stray call entry.
    assign ras_push = ras_push_i && !misalign_d &&
                      (sel == PC_SEL_BR || sel == PC_SEL_RET || sel == PC_SEL_SEQ);
    assign ras_pop  = (sel == PC_SEL_RET);
    assign uflow_d  = (sel == PC_SEL_SEQ) && ras_pop_i && ras_empty_o;

    otter_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (ras_push),
        .pop_i      (ras_pop),
        .push_dat_i (pc_seq),
        .top_o      (ras_top),
        .empty_o    (ras_empty_o),
        .full_o     (ras_full_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q       <= RESET_VEC;
            uflow_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            uflow_q    <= uflow_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_count_o  = pc_q;
    assign pc_next_o   = pc_d;
    assign ras_uflow_o = uflow_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_otter_pc_unit.sv
// Directed test of otter_pc_unit with hand-computed expected PC and flag values.
module tb_otter_pc_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        pc_stall_i, trap_en_i, br_en_i, ras_push_i, ras_pop_i;
    logic [31:0] trap_vec_i, br_tgt_i;
    logic [31:0] pc_count_o, pc_next_o;
    logic        ras_empty_o, ras_full_o, ras_uflow_o, misalign_o;

    int total = 0;
    int bad   = 0;

    otter_pc_unit dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .pc_stall_i  (pc_stall_i),
        .trap_en_i   (trap_en_i),
        .trap_vec_i  (trap_vec_i),
        .br_en_i     (br_en_i),
        .br_tgt_i    (br_tgt_i),
        .ras_push_i  (ras_push_i),
        .ras_pop_i   (ras_pop_i),
        .pc_count_o  (pc_count_o),
        .pc_next_o   (pc_next_o),
        .ras_empty_o (ras_empty_o),
        .ras_full_o  (ras_full_o),
        .ras_uflow_o (ras_uflow_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_stall_i = 0; trap_en_i = 0; br_en_i = 0; ras_push_i = 0; ras_pop_i = 0;
        trap_vec_i = '0; br_tgt_i = '0;
    endtask

    // Apply one cycle of inputs, clock it, then return inputs to idle.
    task automatic cyc(input logic stall, input logic trap, input logic [31:0] tv,
                       input logic br, input logic [31:0] bt, input logic push, input logic pop);
        pc_stall_i = stall; trap_en_i = trap; trap_vec_i = tv;
        br_en_i = br; br_tgt_i = bt; ras_push_i = push; ras_pop_i = pop;
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic go_to(input logic [31:0] pc);
        cyc(0, 1, pc, 0, 0, 0, 0);
    endtask

    initial begin
        idle_inputs();
        rst_n_i = 0;
        #3;
        chk("rst_pc", pc_count_o, 32'h0);
        chk("rst_empty", 32'(ras_empty_o), 1);
        chk("rst_full", 32'(ras_full_o), 0);
        chk("rst_uflow", 32'(ras_uflow_o), 0);
        chk("rst_misalign", 32'(misalign_o), 0);
        @(negedge clk_i) rst_n_i = 1;

        // 1: run, push, then reset asynchronously mid-cycle
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t1_seq", pc_count_o, 32'h4);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("t1_push_pc", pc_count_o, 32'h8);
        chk("t1_push_nempty", 32'(ras_empty_o), 0);
        #2 rst_n_i = 0;
        #1;
        chk("t1_async_pc", pc_count_o, 32'h0);
        chk("t1_async_empty", 32'(ras_empty_o), 1);
        @(negedge clk_i) rst_n_i = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t1_pc4", pc_count_o, 32'h4);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t1_pc8", pc_count_o, 32'h8);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t1_pc12", pc_count_o, 32'hC);

        // 2: stall holds (and blocks push/branch), trap overrides stall
        go_to(32'h100);
        chk("t2_trap_in", pc_count_o, 32'h100);
        cyc(1, 0, 0, 1, 32'h500, 1, 0);
        chk("t2_stall1", pc_count_o, 32'h100);
        chk("t2_stall_nopush", 32'(ras_empty_o), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("t2_stall2", pc_count_o, 32'h100);
        cyc(1, 1, 32'h200, 0, 0, 1, 0);
        chk("t2_trap_stall", pc_count_o, 32'h200);
        chk("t2_trap_nopush", 32'(ras_empty_o), 1);

        // 3: branch with call push, then return
        go_to(32'h40);
        cyc(0, 0, 0, 1, 32'h80, 1, 0);
        chk("t3_br", pc_count_o, 32'h80);
        chk("t3_nempty", 32'(ras_empty_o), 0);
        ras_pop_i = 1;
        #1;
        chk("t3_next_comb", pc_next_o, 32'h44);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t3_ret", pc_count_o, 32'h44);
        chk("t3_empty", 32'(ras_empty_o), 1);

        // 4: five pushes into a 4-deep stack, LIFO pops, then underflow
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0);
            chk("t4_push_pc", pc_count_o, 32'h48 + 32'(4 * i));
            if (i == 2) chk("t4_not_full3", 32'(ras_full_o), 0);
            if (i >= 3) chk("t4_full", 32'(ras_full_o), 1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            chk("t4_pop", pc_count_o, 32'h58 - 32'(4 * i));
        end
        chk("t4_empty", 32'(ras_empty_o), 1);
        chk("t4_nofull", 32'(ras_full_o), 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t4_uflow_pc", pc_count_o, 32'h50);
        chk("t4_uflow", 32'(ras_uflow_o), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t4_uflow_clr", 32'(ras_uflow_o), 0);
        chk("t4_seq", pc_count_o, 32'h54);

        // 5: misaligned branch/trap rejected; trap beats branch
        cyc(0, 0, 0, 1, 32'h102, 1, 0);
        chk("t5_mis_hold", pc_count_o, 32'h54);
        chk("t5_mis_flag", 32'(misalign_o), 1);
        chk("t5_mis_nopush", 32'(ras_empty_o), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t5_mis_clr", 32'(misalign_o), 0);
        chk("t5_seq", pc_count_o, 32'h58);
        cyc(0, 1, 32'h300, 1, 32'h80, 0, 0);
        chk("t5_trap_wins", pc_count_o, 32'h300);
        chk("t5_trap_ok", 32'(misalign_o), 0);
        cyc(0, 1, 32'h202, 0, 0, 0, 0);
        chk("t5_trapmis_hold", pc_count_o, 32'h300);
        chk("t5_trapmis_flag", 32'(misalign_o), 1);

        // 6: wrap, then push+pop replaces top in place
        go_to(32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t6_wrap", pc_count_o, 32'h0);
        go_to(32'h2FC);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("t6_pc300", pc_count_o, 32'h300);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("t6_pushpop_pc", pc_count_o, 32'h300);
        chk("t6_pushpop_nempty", 32'(ras_empty_o), 0);
        chk("t6_pushpop_nfull", 32'(ras_full_o), 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t6_new_top", pc_count_o, 32'h304);
        chk("t6_count1", 32'(ras_empty_o), 1);

        // push+pop on empty: pop ignored with underflow, push proceeds
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("t6_pp_empty_pc", pc_count_o, 32'h308);
        chk("t6_pp_empty_uflow", 32'(ras_uflow_o), 1);
        chk("t6_pp_empty_pushed", 32'(ras_empty_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
